// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states
// and the signedness rules used when operands are accepted.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct7 of every RV32M R-type op; decode uses it to route ops to this unit.
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic {MODE_MUL, MODE_DIV} mode_t;

  function automatic logic signed_a(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage (master) and the M-unit (slave).
interface muldiv_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, srcA, srcB,
                  input  busy, done, stall, result);

  modport slave  (input  start, funct3, srcA, srcB,
                  output busy, done, stall, result);

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on the shared
// double-width accumulator {hi, lo}.
module muldiv_step import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  mode_t             mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] rem_sub;
  logic            ge;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge       = shifted >= {1'b0, opnd};
    rem_sub  = shifted[XLEN-1:0] - opnd;
    acc_next = {sum, acc[XLEN-1:1]};
    if (mode == MODE_DIV)
      acc_next = {(ge ? rem_sub : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M sequencer: accepts one op, iterates one bit per cycle on magnitudes, applies
// sign correction on entry to DONE. Special divides resolve straight from IDLE.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   opnd, result_q;
  logic [2:0]        op;
  logic              neg_res;

  logic              a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val, final_val;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   quo, rem;

  // Operand decode at accept.
  always_comb begin
    a_neg    = signed_a(bus.funct3) & bus.srcA[XLEN-1];
    b_neg    = signed_b(bus.funct3) & bus.srcB[XLEN-1];
    a_mag    = a_neg ? -bus.srcA : bus.srcA;
    b_mag    = b_neg ? -bus.srcB : bus.srcB;
    div_zero = (bus.srcB == '0);
    ovf      = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
               (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcB == '1);
    special  = bus.funct3[2] & (div_zero | ovf);
    if (div_zero)
      special_val = bus.funct3[1] ? bus.srcA : '1;
    else
      special_val = bus.funct3[1] ? '0 : bus.srcA;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .mode     (op[2] ? MODE_DIV : MODE_MUL),
    .acc_next (acc_next)
  );

  // Sign-corrected result built from the last iteration's output.
  always_comb begin
    mul_full = neg_res ? -acc_next : acc_next;
    quo      = acc_next[XLEN-1:0];
    rem      = acc_next[2*XLEN-1:XLEN];
    unique case (op)
      F3_MUL:                    final_val = mul_full[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:                  final_val = mul_full[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:           final_val = neg_res ? -quo : quo;
      default:                   final_val = neg_res ? -rem : rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = special ? DONE : BUSY;
      BUSY:    if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state == BUSY);
    bus.done   = (state == DONE);
    bus.stall  = bus.start & ~bus.done;
    bus.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= F3_MUL;
      neg_res  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op      <= bus.funct3;
          // Remainder follows the dividend; everything else follows the operand signs.
          neg_res <= (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
          count   <= CW'(XLEN-1);
          opnd    <= bus.funct3[2] ? b_mag : a_mag;
          acc     <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
          if (special) result_q <= special_val;
        end
        BUSY: begin
          acc <= acc_next;
          if (count == '0) result_q <= final_val;
          else             count    <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, reset abort, back-to-back
// timing and randomized ops against a wide-integer reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issue one op at the current negedge (cycle 0) and check result, latency and busy span.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int          busy_n, done_at, lat;
    logic [31:0] res;
    logic        st_done;
    logic        sp;
    sp  = f3[2] && (b == 0 || ((f3 == F3_DIV || f3 == F3_REM) &&
                               a == 32'h80000000 && b == 32'hFFFFFFFF));
    lat = sp ? 1 : 33;
    bus.start = 1'b1; bus.funct3 = f3; bus.srcA = a; bus.srcB = b;
    #1;
    check($sformatf("%s_stall_c0", name), bus.stall, 1);
    busy_n = 0; done_at = -1; res = '0; st_done = 1'b1;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      tick();
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = c; res = bus.result; st_done = bus.stall;
      end
      if (c == 2) begin
        bus.srcA = $urandom; bus.srcB = $urandom; bus.funct3 = 3'($urandom);
      end
    end
    bus.start = 1'b0;
    check($sformatf("%s_result", name), res, exp);
    check($sformatf("%s_done_cycle", name), done_at, lat);
    check($sformatf("%s_busy_cycles", name), busy_n, sp ? 0 : 32);
    check($sformatf("%s_stall_at_done", name), st_done, 0);
    tick();
    check($sformatf("%s_result_hold", name), bus.result, exp);
  endtask

  initial begin
    int          done_cnt, done_at;
    logic [2:0]  f3;
    logic [31:0] a, b;

    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.srcA = '0; bus.srcB = '0;
    @(negedge clk);
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_stall", bus.stall, 0);
    reset = 1'b0;
    tick();

    run_op(F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7xm3");
    run_op(F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    run_op(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run_op(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    run_op(F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
    run_op(F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
    run_op(F3_DIVU,   32'd100,      32'd7,        32'd14,       "divu_100_7");
    run_op(F3_REMU,   32'd100,      32'd7,        32'd2,        "remu_100_7");
    run_op(F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0");
    run_op(F3_REM,    32'd5,        32'd0,        32'd5,        "rem_by0");
    run_op(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");

    // Reset in the middle of a divide aborts it without a done pulse.
    bus.start = 1'b1; bus.funct3 = F3_DIV; bus.srcA = 32'hFFFFFFF9; bus.srcB = 32'd2;
    for (int c = 1; c <= 10; c++) tick();
    reset = 1'b1; bus.start = 1'b0;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_op(F3_MUL, 32'd3, 32'd4, 32'd12, "mul_after_abort");

    // start held through done, operand change mid-op, then back-to-back accept.
    done_cnt = 0;
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.srcA = 32'd5; bus.srcB = 32'd6;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (bus.done) done_cnt++;
      if (c == 5) bus.srcA = 32'd100;
    end
    check("b2b_done_c33", bus.done, 1);
    check("b2b_result1", bus.result, 32'd30);
    bus.srcA = 32'd9; bus.srcB = 32'd9;
    tick();
    if (bus.done) done_cnt++;
    check("b2b_c34_busy", bus.busy, 0);
    check("b2b_single_done", done_cnt, 1);
    tick();
    check("b2b_c35_busy", bus.busy, 1);
    done_at = -1;
    for (int c = 36; c <= 80 && done_at < 0; c++) begin
      tick();
      if (bus.done) done_at = c;
    end
    bus.start = 1'b0;
    check("b2b_done2_cycle", done_at, 67);
    check("b2b_result2", bus.result, 32'd81);
    tick();

    // Randomized ops with a bias toward divide corner cases.
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = 32'h80000000;
        default: ;
      endcase
      run_op(f3, a, b, ref_model(f3, a, b), $sformatf("rnd%0d_f3_%0d", i, f3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
